// File: rtl/tx_pkt_enqueue.sv
// rtl/tx_pkt_enqueue.sv - TX packet enqueue into the TX data FIFO with framing checks, overflow drop and statistics
module tx_pkt_enqueue #(
    parameter int  DATA_W = 64,
    parameter int  CNT_W  = 16,
    localparam int MOD_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25_n,
    input  logic [DATA_W-1:0] pkt_tx_data,
    input  logic              pkt_tx_val,
    input  logic              pkt_tx_sop,
    input  logic              pkt_tx_eop,
    input  logic [MOD_W-1:0]  pkt_tx_mod,
    input  logic              txdfifo_wfull,
    input  logic              txdfifo_walmost_full,
    input  logic              stat_clr,
    output logic              pkt_tx_full,
    output logic [DATA_W-1:0] txdfifo_wdata,
    output logic [7:0]        txdfifo_wstatus,
    output logic              txdfifo_wen,
    output logic              status_txdfifo_ovflow_tog,
    output logic [CNT_W-1:0]  stat_pkt_cnt,
    output logic [CNT_W-1:0]  stat_drop_cnt,
    output logic [CNT_W-1:0]  stat_frame_err_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DROP} state_t;

    state_t     state, state_nxt;
    logic       abort_pend;
    logic       wr_data, wr_sop, wr_eop, wr_marker;
    logic       set_abort, ovflow, pkt_inc, ferr_inc;
    logic [1:0] drop_inc;
    logic [3:0] mod_ext;

    assign mod_ext     = 4'(pkt_tx_mod);
    assign pkt_tx_full = txdfifo_walmost_full | abort_pend;

    // The marker only borrows idle FIFO write slots, so it never collides with data.
    assign wr_marker = abort_pend & ~txdfifo_wfull & ~wr_data;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W + 1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    always_comb begin
        state_nxt = state;
        wr_data   = 1'b0;
        wr_sop    = 1'b0;
        wr_eop    = 1'b0;
        set_abort = 1'b0;
        ovflow    = 1'b0;
        pkt_inc   = 1'b0;
        ferr_inc  = 1'b0;
        drop_inc  = 2'd0;
        if (pkt_tx_val) begin
            case (state)
                ST_IDLE: begin
                    if (!pkt_tx_sop) begin
                        ferr_inc = 1'b1;
                    end else if (txdfifo_wfull || abort_pend) begin
                        ovflow    = 1'b1;
                        drop_inc  = 2'd1;
                        state_nxt = pkt_tx_eop ? ST_IDLE : ST_DROP;
                    end else begin
                        wr_data   = 1'b1;
                        wr_sop    = 1'b1;
                        wr_eop    = pkt_tx_eop;
                        pkt_inc   = pkt_tx_eop;
                        state_nxt = pkt_tx_eop ? ST_IDLE : ST_PKT;
                    end
                end
                ST_PKT: begin
                    if (pkt_tx_sop) begin
                        // Old packet aborted and the new one dropped: two drops at once.
                        set_abort = 1'b1;
                        ferr_inc  = 1'b1;
                        drop_inc  = 2'd2;
                        state_nxt = pkt_tx_eop ? ST_IDLE : ST_DROP;
                    end else if (txdfifo_wfull) begin
                        set_abort = 1'b1;
                        ovflow    = 1'b1;
                        drop_inc  = 2'd1;
                        state_nxt = pkt_tx_eop ? ST_IDLE : ST_DROP;
                    end else begin
                        wr_data   = 1'b1;
                        wr_eop    = pkt_tx_eop;
                        pkt_inc   = pkt_tx_eop;
                        state_nxt = pkt_tx_eop ? ST_IDLE : ST_PKT;
                    end
                end
                ST_DROP: begin
                    ferr_inc = pkt_tx_sop;
                    if (pkt_tx_eop) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state                     <= ST_IDLE;
            abort_pend                <= 1'b0;
            txdfifo_wen               <= 1'b0;
            txdfifo_wdata             <= '0;
            txdfifo_wstatus           <= 8'h00;
            status_txdfifo_ovflow_tog <= 1'b0;
            stat_pkt_cnt              <= '0;
            stat_drop_cnt             <= '0;
            stat_frame_err_cnt        <= '0;
        end else begin
            state       <= state_nxt;
            abort_pend  <= set_abort | (abort_pend & ~wr_marker);
            txdfifo_wen <= wr_data | wr_marker;
            if (wr_data) begin
                txdfifo_wdata   <= pkt_tx_data;
                txdfifo_wstatus <= {2'b00, wr_sop, wr_eop, wr_eop ? mod_ext : 4'h0};
            end else if (wr_marker) begin
                txdfifo_wdata   <= '0;
                txdfifo_wstatus <= 8'h50;
            end
            status_txdfifo_ovflow_tog <= status_txdfifo_ovflow_tog ^ ovflow;
            if (stat_clr) begin
                stat_pkt_cnt       <= '0;
                stat_drop_cnt      <= '0;
                stat_frame_err_cnt <= '0;
            end else begin
                stat_pkt_cnt       <= sat_add(stat_pkt_cnt, {1'b0, pkt_inc});
                stat_drop_cnt      <= sat_add(stat_drop_cnt, drop_inc);
                stat_frame_err_cnt <= sat_add(stat_frame_err_cnt, {1'b0, ferr_inc});
            end
        end
    end

endmodule

// File: tb/tb_tx_pkt_enqueue.sv
// tb/tb_tx_pkt_enqueue.sv - scoreboard bench for tx_pkt_enqueue (DATA_W=128, CNT_W=2)
module tb_tx_pkt_enqueue;

    localparam int DATA_W = 128;
    localparam int CNT_W  = 2;
    localparam int MOD_W  = 4;

    typedef struct {
        int unsigned       cyc;
        logic [DATA_W-1:0] data;
        logic [7:0]        status;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    logic        exp_tog = 1'b0;

    logic              clk_156m25 = 1'b0;
    logic              reset_156m25_n;
    logic [DATA_W-1:0] pkt_tx_data;
    logic              pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
    logic [MOD_W-1:0]  pkt_tx_mod;
    logic              txdfifo_wfull, txdfifo_walmost_full, stat_clr;
    logic              pkt_tx_full;
    logic [DATA_W-1:0] txdfifo_wdata;
    logic [7:0]        txdfifo_wstatus;
    logic              txdfifo_wen;
    logic              status_txdfifo_ovflow_tog;
    logic [CNT_W-1:0]  stat_pkt_cnt, stat_drop_cnt, stat_frame_err_cnt;

    tx_pkt_enqueue #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_156m25               (clk_156m25),
        .reset_156m25_n           (reset_156m25_n),
        .pkt_tx_data              (pkt_tx_data),
        .pkt_tx_val               (pkt_tx_val),
        .pkt_tx_sop               (pkt_tx_sop),
        .pkt_tx_eop               (pkt_tx_eop),
        .pkt_tx_mod               (pkt_tx_mod),
        .txdfifo_wfull            (txdfifo_wfull),
        .txdfifo_walmost_full     (txdfifo_walmost_full),
        .stat_clr                 (stat_clr),
        .pkt_tx_full              (pkt_tx_full),
        .txdfifo_wdata            (txdfifo_wdata),
        .txdfifo_wstatus          (txdfifo_wstatus),
        .txdfifo_wen              (txdfifo_wen),
        .status_txdfifo_ovflow_tog(status_txdfifo_ovflow_tog),
        .stat_pkt_cnt             (stat_pkt_cnt),
        .stat_drop_cnt            (stat_drop_cnt),
        .stat_frame_err_cnt       (stat_frame_err_cnt)
    );

    initial forever #5 clk_156m25 = ~clk_156m25;

    always @(posedge clk_156m25) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_156m25) begin : monitor
        exp_t e;
        if (txdfifo_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got status %02h data %0h want no write (cycle %0d)",
                         txdfifo_wstatus, txdfifo_wdata, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("wr_cycle", DATA_W'(cyc), DATA_W'(e.cyc));
                chk("wr_data", txdfifo_wdata, e.data);
                chk("wr_status", DATA_W'(txdfifo_wstatus), DATA_W'(e.status));
            end
        end
    end

    task automatic expect_wr(input logic [DATA_W-1:0] d, input logic [7:0] st);
        exp_t e;
        e.cyc    = cyc + 1;
        e.data   = d;
        e.status = st;
        exp_q.push_back(e);
    endtask

    task automatic word(input logic s, input logic e, input logic [3:0] m,
                        input logic [DATA_W-1:0] d, input logic wf);
        pkt_tx_val    = 1'b1;
        pkt_tx_sop    = s;
        pkt_tx_eop    = e;
        pkt_tx_mod    = m;
        pkt_tx_data   = d;
        txdfifo_wfull = wf;
        @(posedge clk_156m25);
        #1;
        pkt_tx_val = 1'b0;
        pkt_tx_sop = 1'b0;
        pkt_tx_eop = 1'b0;
    endtask

    task automatic idle(input logic wf);
        txdfifo_wfull = wf;
        @(posedge clk_156m25);
        #1;
    endtask

    task automatic clr_stats();
        stat_clr = 1'b1;
        idle(1'b0);
        stat_clr = 1'b0;
    endtask

    task automatic chk_stats(input logic [1:0] p, input logic [1:0] dr, input logic [1:0] fe, input string tag);
        chk({tag, "_pkt_cnt"}, DATA_W'(stat_pkt_cnt), DATA_W'(p));
        chk({tag, "_drop_cnt"}, DATA_W'(stat_drop_cnt), DATA_W'(dr));
        chk({tag, "_frame_err_cnt"}, DATA_W'(stat_frame_err_cnt), DATA_W'(fe));
    endtask

    initial begin
        logic [1:0] sat_seq [5];
        sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        reset_156m25_n       = 1'b0;
        pkt_tx_data          = '0;
        pkt_tx_val           = 1'b0;
        pkt_tx_sop           = 1'b0;
        pkt_tx_eop           = 1'b0;
        pkt_tx_mod           = '0;
        txdfifo_wfull        = 1'b0;
        txdfifo_walmost_full = 1'b1;
        stat_clr             = 1'b0;
        repeat (3) @(posedge clk_156m25);
        #1;

        // reset state
        chk("rst_wen", DATA_W'(txdfifo_wen), 0);
        chk("rst_wdata", txdfifo_wdata, 0);
        chk("rst_wstatus", DATA_W'(txdfifo_wstatus), 0);
        chk("rst_tog", DATA_W'(status_txdfifo_ovflow_tog), 0);
        chk_stats(0, 0, 0, "rst");
        chk("rst_full_hi", DATA_W'(pkt_tx_full), 1);
        txdfifo_walmost_full = 1'b0;
        #1;
        chk("rst_full_lo", DATA_W'(pkt_tx_full), 0);
        reset_156m25_n = 1'b1;
        idle(1'b0);

        // three-word packet, mod 5
        expect_wr(128'h1111, 8'h20); word(1, 0, 0, 128'h1111, 0);
        expect_wr(128'h2222, 8'h00); word(0, 0, 5, 128'h2222, 0);
        expect_wr(128'h3333, 8'h15); word(0, 1, 5, 128'h3333, 0);
        chk_stats(1, 0, 0, "t1");

        // overflow on word 2 of a 4-word packet
        clr_stats();
        expect_wr(128'h4441, 8'h20); word(1, 0, 0, 128'h4441, 0);
        word(0, 0, 0, 128'h4442, 1);
        exp_tog = ~exp_tog;
        chk("t2_full_abort", DATA_W'(pkt_tx_full), 1);
        chk("t2_tog", DATA_W'(status_txdfifo_ovflow_tog), DATA_W'(exp_tog));
        chk_stats(0, 1, 0, "t2");
        word(0, 0, 0, 128'h4443, 1);
        word(0, 1, 3, 128'h4444, 1);
        idle(1'b1);
        chk("t2_full_hold", DATA_W'(pkt_tx_full), 1);
        expect_wr(128'h0, 8'h50); idle(1'b0);
        chk("t2_full_clear", DATA_W'(pkt_tx_full), 0);
        chk("t2_tog_once", DATA_W'(status_txdfifo_ovflow_tog), DATA_W'(exp_tog));
        chk_stats(0, 1, 0, "t2b");

        // overflow on an EOP word, then a sop while the marker is still owed
        clr_stats();
        expect_wr(128'h4451, 8'h20); word(1, 0, 0, 128'h4451, 0);
        word(0, 1, 2, 128'h4452, 1);
        exp_tog = ~exp_tog;
        expect_wr(128'h0, 8'h50); word(1, 1, 1, 128'h4453, 0);
        exp_tog = ~exp_tog;
        chk("t2c_full", DATA_W'(pkt_tx_full), 0);
        chk("t2c_tog", DATA_W'(status_txdfifo_ovflow_tog), DATA_W'(exp_tog));
        chk_stats(0, 2, 0, "t2c");

        // sop inside a packet (missing EOP)
        clr_stats();
        expect_wr(128'h5551, 8'h20); word(1, 0, 0, 128'h5551, 0);
        expect_wr(128'h5552, 8'h00); word(0, 0, 0, 128'h5552, 0);
        word(1, 0, 0, 128'h5553, 0);
        chk("t3_full", DATA_W'(pkt_tx_full), 1);
        expect_wr(128'h0, 8'h50); word(0, 0, 0, 128'h5554, 0);
        word(0, 1, 7, 128'h5555, 0);
        chk("t3_full_clear", DATA_W'(pkt_tx_full), 0);
        chk("t3_tog", DATA_W'(status_txdfifo_ovflow_tog), DATA_W'(exp_tog));
        chk_stats(0, 2, 1, "t3");

        // words in IDLE without sop
        clr_stats();
        word(0, 0, 0, 128'h6661, 0);
        word(0, 1, 4, 128'h6662, 0);
        idle(1'b0);
        chk_stats(0, 0, 2, "t4");

        // back-to-back single-word packets, mod 9, pkt_cnt saturates at 3
        clr_stats();
        for (int i = 0; i < 4; i++) begin
            expect_wr(128'hA000 + 128'(i), 8'h39);
            word(1, 1, 9, 128'hA000 + 128'(i), 0);
            chk("t5_pkt_cnt", DATA_W'(stat_pkt_cnt), DATA_W'(sat_seq[i]));
        end

        // five overflow drops, drop_cnt saturates at 3
        clr_stats();
        for (int i = 0; i < 5; i++) begin
            word(1, 1, 0, 128'hB000 + 128'(i), 1);
            exp_tog = ~exp_tog;
            chk("t6_drop_cnt", DATA_W'(stat_drop_cnt), DATA_W'(sat_seq[i]));
        end
        chk("t6_tog", DATA_W'(status_txdfifo_ovflow_tog), DATA_W'(exp_tog));
        stat_clr = 1'b1;
        word(1, 1, 0, 128'hB005, 1);
        exp_tog = ~exp_tog;
        stat_clr = 1'b0;
        chk_stats(0, 0, 0, "t6_clr");
        chk("t6_tog_clr", DATA_W'(status_txdfifo_ovflow_tog), DATA_W'(exp_tog));

        // reset in the middle of a packet
        word(0, 0, 0, 128'h7771, 0);
        chk("t7_ferr_pre", DATA_W'(stat_frame_err_cnt), 1);
        word(1, 0, 2, 128'h7772, 0);
        chk("t7_wen_pre", DATA_W'(txdfifo_wen), 1);
        chk("t7_status_pre", DATA_W'(txdfifo_wstatus), 8'h20);
        reset_156m25_n = 1'b0;
        #1;
        exp_tog = 1'b0;
        chk("t7_wen", DATA_W'(txdfifo_wen), 0);
        chk("t7_wdata", txdfifo_wdata, 0);
        chk("t7_wstatus", DATA_W'(txdfifo_wstatus), 0);
        chk("t7_tog", DATA_W'(status_txdfifo_ovflow_tog), DATA_W'(exp_tog));
        chk_stats(0, 0, 0, "t7");
        txdfifo_walmost_full = 1'b1;
        #1;
        chk("t7_full", DATA_W'(pkt_tx_full), 1);
        txdfifo_walmost_full = 1'b0;
        idle(1'b0);
        reset_156m25_n = 1'b1;
        idle(1'b0);
        word(0, 1, 1, 128'h7773, 0);
        idle(1'b0);
        idle(1'b0);
        chk_stats(0, 0, 1, "t7_post");
        chk("t7_full_post", DATA_W'(pkt_tx_full), 0);

        chk("queue_empty", DATA_W'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
